// File: rtl/pool_window_gen_pkg.sv
// Shared pooling parameters for the AlexNet pipeline: element width, pool kernel/stride,
// per-layer feature-map sizes and the window-generator state encoding.
package pool_window_gen_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int POOL_KERNEL = 3;
  localparam int POOL_STRIDE = 2;
  localparam int POOL_SIZE   = POOL_KERNEL * POOL_KERNEL * DATA_WIDTH;

  // Feature-map edge lengths at the inputs of the three max-pool stages
  localparam int CONV1_FM = 55;
  localparam int CONV2_FM = 27;
  localparam int CONV5_FM = 13;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } pool_state_e;

  // Number of full pooling windows along one dimension of a feature map
  function automatic int out_dim(input int fm_size, input int stride);
    return (fm_size - POOL_KERNEL) / stride + 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// One feature-map row of storage: synchronous write, combinational read that returns
// the pre-write contents when the same address is written in the same cycle.
module pool_line_buffer
  import pool_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = pool_window_gen_pkg::DATA_WIDTH,
  parameter int DEPTH      = CONV1_FM,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rd_data = mem_r[addr];

  // Row storage update; contents are never cleared because every slot is rewritten before use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 3x3 window generator feeding the max-pool stage: two line buffers plus a
// 3x3 register window turn a raster-order channel into packed strided windows.
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = pool_window_gen_pkg::DATA_WIDTH,
  parameter int FM_WIDTH   = CONV1_FM,
  parameter int FM_HEIGHT  = CONV1_FM,
  parameter int STRIDE     = POOL_STRIDE
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          in_valid,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  output logic                                          in_ready,
  output logic                                          win_valid,
  output logic [POOL_KERNEL*POOL_KERNEL*DATA_WIDTH-1:0] win_vector,
  output logic                                          frame_done,
  output logic                                          busy
);

  localparam int OUT_W     = out_dim(FM_WIDTH, STRIDE);
  localparam int OUT_H     = out_dim(FM_HEIGHT, STRIDE);
  localparam int COL_BITS  = $clog2(FM_WIDTH);
  localparam int ROW_BITS  = $clog2(FM_HEIGHT);
  localparam int PH_BITS   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WIN_ELEMS = POOL_KERNEL * POOL_KERNEL;
  // Right/bottom edge of the last window that fits in the map
  localparam int LAST_X    = POOL_KERNEL - 1 + (OUT_W - 1) * STRIDE;
  localparam int LAST_Y    = POOL_KERNEL - 1 + (OUT_H - 1) * STRIDE;

  pool_state_e state_r;
  pool_state_e state_next_s;

  logic [COL_BITS-1:0] x_r;
  logic [ROW_BITS-1:0] y_r;
  logic [PH_BITS-1:0]  xph_r;
  logic [PH_BITS-1:0]  yph_r;

  logic accept_s;
  logic start_s;
  logic last_x_s;
  logic last_y_s;
  logic col_hit_s;
  logic row_hit_s;
  logic emit_s;
  logic final_s;

  logic [DATA_WIDTH-1:0] lb1_rd_s;
  logic [DATA_WIDTH-1:0] lb2_rd_s;

  logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_r;
  logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_next_s;
  logic [WIN_ELEMS-1:0][DATA_WIDTH-1:0] win_vector_r;
  logic                                 win_valid_r;
  logic                                 frame_done_r;

  // Phase tracks (pos-2) mod STRIDE so no divider is needed; it stays 0 until the window fits
  function automatic logic [PH_BITS-1:0] step_phase(input logic [PH_BITS-1:0] ph,
                                                     input logic            active);
    logic [PH_BITS-1:0] nxt;
    if (!active) begin
      nxt = PH_BITS'(0);
    end else if (ph == PH_BITS'(STRIDE - 1)) begin
      nxt = PH_BITS'(0);
    end else begin
      nxt = ph + PH_BITS'(1);
    end
    return nxt;
  endfunction

  assign accept_s = in_valid && (state_r == ST_STREAM);
  assign start_s  = start && (state_r == ST_IDLE);
  assign last_x_s = (x_r == COL_BITS'(FM_WIDTH - 1));
  assign last_y_s = (y_r == ROW_BITS'(FM_HEIGHT - 1));

  assign in_ready   = (state_r == ST_STREAM);
  assign busy       = (state_r == ST_STREAM);
  assign win_valid  = win_valid_r;
  assign win_vector = win_vector_r;
  assign frame_done = frame_done_r;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: leave STREAM right after the bottom-right element is taken
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s && last_x_s && last_y_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Raster position of the element currently presented, plus its stride phases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r   <= COL_BITS'(0);
      y_r   <= ROW_BITS'(0);
      xph_r <= PH_BITS'(0);
      yph_r <= PH_BITS'(0);
    end else if (start_s) begin
      x_r   <= COL_BITS'(0);
      y_r   <= ROW_BITS'(0);
      xph_r <= PH_BITS'(0);
      yph_r <= PH_BITS'(0);
    end else if (accept_s) begin
      if (last_x_s) begin
        x_r   <= COL_BITS'(0);
        xph_r <= PH_BITS'(0);
        if (last_y_s) begin
          y_r   <= ROW_BITS'(0);
          yph_r <= PH_BITS'(0);
        end else begin
          y_r   <= y_r + ROW_BITS'(1);
          yph_r <= step_phase(yph_r, y_r >= ROW_BITS'(2));
        end
      end else begin
        x_r   <= x_r + COL_BITS'(1);
        xph_r <= step_phase(xph_r, x_r >= COL_BITS'(2));
      end
    end
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FM_WIDTH),
    .ADDR_BITS  (COL_BITS)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (accept_s),
    .addr    (x_r),
    .wr_data (in_data),
    .rd_data (lb1_rd_s)
  );

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FM_WIDTH),
    .ADDR_BITS  (COL_BITS)
  ) u_lb2 (
    .clk     (clk),
    .wr_en   (accept_s),
    .addr    (x_r),
    .wr_data (lb1_rd_s),
    .rd_data (lb2_rd_s)
  );

  // Window after this element: shift left, new right column is {row y-2, row y-1, row y}
  always_comb begin
    win_next_s = win_r;
    for (int r = 0; r < POOL_KERNEL; r++) begin
      for (int c = 0; c < POOL_KERNEL - 1; c++) begin
        win_next_s[r*POOL_KERNEL + c] = win_r[r*POOL_KERNEL + c + 1];
      end
    end
    win_next_s[2] = lb2_rd_s;
    win_next_s[5] = lb1_rd_s;
    win_next_s[8] = in_data;
  end

  // Register window; columns from the previous row are flushed out before x reaches 2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_r <= '0;
    end else if (accept_s) begin
      win_r <= win_next_s;
    end
  end

  // Emit decision for the element being accepted this cycle
  always_comb begin
    col_hit_s = (x_r >= COL_BITS'(2)) && (x_r <= COL_BITS'(LAST_X)) && (xph_r == PH_BITS'(0));
    row_hit_s = (y_r >= ROW_BITS'(2)) && (y_r <= ROW_BITS'(LAST_Y)) && (yph_r == PH_BITS'(0));
    emit_s    = accept_s && col_hit_s && row_hit_s;
    final_s   = emit_s && (x_r == COL_BITS'(LAST_X)) && (y_r == ROW_BITS'(LAST_Y));
  end

  // Output registers; the vector holds the last window between emits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      win_vector_r <= '0;
    end else begin
      win_valid_r  <= emit_s;
      frame_done_r <= final_s;
      if (emit_s) begin
        win_vector_r <= win_next_s;
      end
    end
  end

endmodule
